// File: rtl/disp_pkg.sv
// Shared constants, types and the leading-zero suppression helper for the
// result display.
package disp_pkg;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_MINUS = 4'hA;
  localparam int         NUM_SLOTS = 6;

  typedef logic [2:0] slot_t;

  // Blanks leading zeros from the MSD (digit 5) down to digit 2; digit 1 is
  // always shown. Codes above 9 count as nonzero and pass through unchanged.
  function automatic logic [19:0] zero_suppress(input logic [19:0] bcd);
    logic [19:0] res;
    logic        lead;
    res  = bcd;
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (lead && (bcd[i*4 +: 4] == 4'h0)) begin
        res[i*4 +: 4] = DIG_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Free-running prescaler: counts 0..PRESCALE-1 and flags the wrap cycle.
module disp_prescaler #(
  parameter int PRESCALE = 50000,
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] count,
  output logic          tick
);

  assign tick = (count == CW'(PRESCALE - 1));

  // Count up, wrap to zero on the terminal cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Six-slot display scan controller: double-buffered result load, leading-zero
// suppression at frame boundaries, slot index and blanked active-low anodes.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500,
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [19:0] load_bcd,
  input  logic        load_neg,
  output slot_t       refreshcounter,
  output logic [3:0]  bcd_d_out_1,
  output logic [3:0]  bcd_d_out_2,
  output logic [3:0]  bcd_d_out_3,
  output logic [3:0]  bcd_d_out_4,
  output logic [3:0]  bcd_d_out_5,
  output logic [3:0]  plus_minus,
  output logic [5:0]  an_n
);

  logic [CW-1:0] pre_count;
  logic          pre_tick;
  logic          frame_wrap;
  logic          shadow_full;
  logic [19:0]   shadow_bcd;
  logic          shadow_neg;
  logic          in_blank;
  logic          transfer;

  disp_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .count (pre_count),
    .tick  (pre_tick)
  );

  assign frame_wrap = pre_tick && (refreshcounter == slot_t'(NUM_SLOTS - 1));
  assign transfer   = frame_wrap && shadow_full;
  assign load_ready = !shadow_full;

  // Slot index advances on every prescaler wrap, 0..5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refreshcounter <= '0;
    end else if (pre_tick) begin
      refreshcounter <= frame_wrap ? '0 : refreshcounter + 1'b1;
    end
  end

  // Shadow buffer: accept when empty, drain on a frame boundary. An accept on
  // a boundary edge (shadow empty) waits for the following boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_full <= 1'b0;
      shadow_bcd  <= '0;
      shadow_neg  <= 1'b0;
    end else if (transfer) begin
      shadow_full <= 1'b0;
    end else if (load_valid && !shadow_full) begin
      shadow_full <= 1'b1;
      shadow_bcd  <= load_bcd;
      shadow_neg  <= load_neg;
    end
  end

  // Active display registers, updated only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {bcd_d_out_5, bcd_d_out_4, bcd_d_out_3, bcd_d_out_2, bcd_d_out_1} <= {5{DIG_BLANK}};
      plus_minus <= DIG_BLANK;
    end else if (transfer) begin
      {bcd_d_out_5, bcd_d_out_4, bcd_d_out_3, bcd_d_out_2, bcd_d_out_1} <= zero_suppress(shadow_bcd);
      plus_minus <= shadow_neg ? DIG_MINUS : DIG_BLANK;
    end
  end

  // With no blanking interval the anode is on for the whole slot.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (pre_count < CW'(BLANK_CYCLES));
    end
  endgenerate

  // One-hot-cold anode decode from registered slot and prescaler phase.
  always_comb begin
    an_n = 6'b111111;
    if (enable && !in_blank) begin
      an_n = 6'b111111 ^ (6'b000001 << refreshcounter);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with PRESCALE=4, BLANK_CYCLES=1.
module tb_display_scan_ctrl;

  localparam int P     = 4;
  localparam int FRAME = 6 * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [19:0] load_bcd = '0;
  logic        load_neg = 1'b0;
  logic [2:0]  refreshcounter;
  logic [3:0]  d1, d2, d3, d4, d5, plus_minus;
  logic [5:0]  an_n;

  display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_bcd       (load_bcd),
    .load_neg       (load_neg),
    .refreshcounter (refreshcounter),
    .bcd_d_out_1    (d1),
    .bcd_d_out_2    (d2),
    .bcd_d_out_3    (d3),
    .bcd_d_out_4    (d4),
    .bcd_d_out_5    (d5),
    .plus_minus     (plus_minus),
    .an_n           (an_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] disp;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [23:0] cur_disp = 24'hFFFFFF;
  int          k = 0;
  logic        acc = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t k=%0d actual=%h required=%h", name, $time, k, act, req);
    end
  endtask

  // Expected {sign, d5..d1}: digits above the most significant nonzero one
  // (never below digit 1) are blank.
  function automatic logic [23:0] model_disp(input logic [19:0] b, input logic n);
    int          top;
    logic [23:0] r;
    top = 1;
    for (int i = 1; i <= 5; i++) if (b[(i-1)*4 +: 4] != 4'h0) top = i;
    for (int i = 1; i <= 5; i++) r[(i-1)*4 +: 4] = (i > top) ? 4'hF : b[(i-1)*4 +: 4];
    r[23:20] = n ? 4'hA : 4'hF;
    return r;
  endfunction

  // Edge counter and accept model: edge k lands at prescaler k%P,
  // slot (k/P)%6; an accept on edge k is shown at the next multiple of FRAME.
  always @(posedge clk) begin
    if (!rst_n) begin
      k   = 0;
      acc = 1'b0;
    end else begin
      k   = k + 1;
      acc = 1'b0;
      if (load_valid && q.size() == 0) begin
        q.push_back('{disp: model_disp(load_bcd, load_neg), due: (k / FRAME + 1) * FRAME});
        acc = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard when an entry falls due and checks outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() != 0 && q[0].due == k) begin
        cur_disp = q[0].disp;
        void'(q.pop_front());
      end
      chk("slot", {29'd0, refreshcounter}, (k / P) % 6);
      chk("an_n", {26'd0, an_n},
          (enable && (k % P) >= 1) ? {26'd0, 6'b111111 ^ (6'b1 << ((k / P) % 6))} : 32'h3F);
      chk("display", {8'd0, plus_minus, d5, d4, d3, d2, d1}, {8'd0, cur_disp});
      chk("load_ready", {31'd0, load_ready}, {31'd0, (q.size() == 0)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [19:0] b, input logic n);
    int t;
    load_bcd   = b;
    load_neg   = n;
    load_valid = 1'b1;
    t = 0;
    do begin
      @(posedge clk);
      #2;
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    load_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int t;
    t = 0;
    while ((k % FRAME) != ph && t < 100) begin
      cyc(1);
      t++;
    end
    if ((k % FRAME) != ph) chk("phase_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [19:0] rand_bcd();
    logic [19:0] r;
    for (int i = 0; i < 5; i++) r[i*4 +: 4] = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom % 16);
    return r;
  endfunction

  initial begin
    #23;
    chk("reset_outputs", {an_n, refreshcounter, d5, d4, d3, d2, d1, plus_minus, load_ready},
        {6'h3F, 3'd0, 24'hFFFFFF, 1'b1});
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Idle scan, then directed loads.
    cyc(30);
    wait_phase(9);
    send(20'h00307, 1'b1);
    cyc(30);
    send(20'h00000, 1'b0);
    cyc(30);

    // Second load held while shadow full.
    send(20'h12345, 1'b0);
    send(20'h0A000, 1'b1);
    cyc(60);

    // Accept on the frame-boundary edge.
    wait_phase(FRAME - 1);
    send(20'h00042, 1'b0);
    cyc(FRAME + 4);

    // Reset mid slot 3 with the shadow full.
    wait_phase(1);
    send(20'h99999, 1'b1);
    wait_phase(13);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {an_n, refreshcounter, d5, d4, d3, d2, d1, plus_minus, load_ready},
        {6'h3F, 3'd0, 24'hFFFFFF, 1'b1});
    q.delete();
    cur_disp = 24'hFFFFFF;
    cyc(3);
    rst_n = 1'b1;
    cyc(2 * FRAME);

    // One frame with enable low while a transfer happens.
    wait_phase(2);
    send(20'h00050, 1'b0);
    wait_phase(0);
    enable = 1'b0;
    cyc(FRAME);
    enable = 1'b1;
    cyc(8);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      load_valid = ($urandom % 4 == 0);
      load_bcd   = rand_bcd();
      load_neg   = 1'($urandom % 2);
      enable     = ($urandom % 8 != 0);
    end
    load_valid = 1'b0;
    enable     = 1'b1;
    cyc(2 * FRAME + 2);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Scan controller for the six-position 7-segment result display: five BCD magnitude digits plus one sign position. It accepts a new multiplier result through a valid/ready handshake and double-buffers it so the display changes only at frame boundaries. It applies leading-zero suppression and generates the 3-bit slot index consumed by the downstream digit mux. It also drives active-low anode enables, with a per-slot blanking interval against ghosting.

## Interface
- PRESCALE, default 50000: clock cycles per digit slot; legal range ≥2.
- BLANK_CYCLES, default 500: cycles at the start of each slot with all anodes off; legal range 0..PRESCALE-1.
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  display on; when low, anodes are off but counters keep running.
- load_valid  in  1  new result offered.
- load_ready  out  1  shadow buffer free; high = accepts load.
- load_bcd  in  20  five BCD digits, [3:0] = units ... [19:16] = MSD.
- load_neg  in  1  result is negative.
- refreshcounter  out  3  current slot 0..5; to the mux select.
- bcd_d_out_1..bcd_d_out_5  out  4 each  active digit codes; units through MSD.
- plus_minus  out  4  sign position code.
- an_n  out  6  anode enables, active-low, one-hot-cold.

## Operation
- Prescaler counts 0..PRESCALE-1 and wraps. The slot counter advances on the cycle the prescaler wraps. Slot sequence is 0,1,2,3,4,5,0, wrapping from 5 to 0.
- Frame boundary: the clock edge on which the slot goes 5→0.
- Shadow buffer, one entry. A load is accepted on an edge where load_valid && load_ready. It captures load_bcd and load_neg, and sets shadow_full.
- load_ready = !shadow_full, combinational from the flag.
- Transfer: on a frame-boundary edge with shadow_full=1 before that edge:
  - the active registers are loaded with the suppressed codes;
  - shadow_full clears.
- An accept and a frame boundary on the same edge (shadow empty before the edge): the data goes to the shadow only and is transferred at the next boundary.
- Leading-zero suppression is computed at transfer. It scans from the MSD (digit 5) down to digit 2. Each digit equal to 0 is replaced by DIG_BLANK until the first nonzero digit. Digit 1 is never suppressed, so all zeros displays "0".
- Sign position: load_neg=1 → DIG_MINUS (4'hA); load_neg=0 → DIG_BLANK (4'hF). Negative zero displays minus and "0"; this is not corrected.
- Digit codes above 9 pass through unchanged and count as nonzero for suppression.
- Anodes: an_n[refreshcounter]=0 only when enable=1 and prescaler ≥ BLANK_CYCLES. Otherwise an_n = 6'b111111.
- enable has no effect on the handshake, transfer or counters.

## Timing
- Reset values: prescaler 0, refreshcounter 0, an_n 6'b111111, bcd_d_out_1..5 = 4'hF, plus_minus = 4'hF, shadow_full 0, load_ready 1.
- Reset is asynchronous. Asserting it mid-frame or mid-handshake discards the shadow and active contents immediately. Operation restarts at slot 0, prescaler 0.
- All outputs are registered, except load_ready (decoded from shadow_full) and an_n (decoded from registered state, glitch-free per edge).
- Slot length: exactly PRESCALE cycles. Frame length: 6×PRESCALE cycles.
- Load-to-display latency: active outputs change on the first frame boundary strictly after the accept edge. The worst case is 6×PRESCALE cycles.
- At most one load is accepted per frame while the shadow is full. load_ready returns high the cycle after the transfer edge.
- With BLANK_CYCLES=0 there is no blanking: an anode is on for the full slot.

## Structure
- Shared package disp_pkg holds:
  - DIG_BLANK = 4'hF, DIG_MINUS = 4'hA, NUM_SLOTS = 6;
  - typedef slot_t (logic [2:0]);
  - the function zero_suppress(logic [19:0]) returning five 4-bit codes.
- Sub-module disp_prescaler (parameter PRESCALE): outputs the prescaler count and a wrap tick. It is reused by other timed blocks.
- The remaining logic is one module: slot counter, shadow/active registers, handshake, anode decode.

## Test plan
Bench parameters for all scenarios: PRESCALE=4, BLANK_CYCLES=1 (frame = 24 cycles).
- Reset then idle → refreshcounter sequence 0..5 with each value held for 4 cycles; an_n[slot]=0 only in prescaler phases 1–3; all digit outputs 4'hF; load_ready=1.
- Load load_bcd=20'h00307, load_neg=1 mid-frame → load_ready drops the next cycle; at the next boundary outputs become {d5..d1} = F,F,3,0,7 and plus_minus = A; load_ready rises one cycle later.
- Load 20'h00000, neg=0 → d1=0, d2..d5 = F, plus_minus = F.
- Second load_valid held while the shadow is full → not accepted until after the transfer; the second value appears one frame after the first.
- load_valid asserted on the frame-boundary cycle with the shadow empty → the value is displayed one full frame later, not at that boundary.
- rst_n pulsed low mid-slot 3 with the shadow full → all outputs return to reset values asynchronously, and the shadow content never appears after release.
- enable=0 for one frame → an_n stays 6'b111111, while refreshcounter and transfers proceed normally.
